periph_buttons: RTL and testbench
=================================

Name: periph_buttons

Overview:
Memory-mapped input peripheral on the iobus; upstream source of button data consumed by the CPU through the same load/store path as periph_leds.
- Synchronises and debounces the 8 raw g_buttons inputs.
- Latches press events into sticky, write-1-to-clear flags.
- Counts presses.
- Answers CPU read/write requests with a one-cycle registered ready handshake.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples required before a debounced level changes; legal range 1..255.
- CNT_W, 8: width of each per-button debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
- g_clk  input  1  system clock; all state updates on rising edge.
- g_rst  input  1  reset, synchronous, active-high.
- g_buttons  input  8  raw asynchronous button levels, 1 = pressed.
- sel  input  1  iobus decode: access targets this peripheral.
- cpu_addr  input  4  byte offset within the peripheral; only bits [3:2] are used.
- cpu_read  input  1  read request, held until cpu_ready.
- cpu_write  input  1  write request, held until cpu_ready.
- cpu_wdata  input  32  write data.
- cpu_rdata  output  32  read data, valid while cpu_ready=1.
- cpu_ready  output  1  access complete, one-cycle pulse.

Behaviour:
- Reset, synchronous, on g_rst=1 at a clock edge:
  - cpu_ready=0, cpu_rdata=0.
  - Synchroniser flops, STATE, EVENTS and COUNT = 0.
  - MASK = 8'hFF.
  - All debounce counters = 0.
  - Reset mid-access aborts the access: no ready pulse is issued and no write takes effect.
- Synchroniser: two flops per bit; sync output lags g_buttons by 2 cycles.
- Debounce, per bit i:
  - If sync[i] == STATE[i], the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, STATE[i] <= sync[i] and the counter clears.
  - Net effect: a clean edge on g_buttons appears in STATE 2+DEBOUNCE_CYCLES cycles later. Any glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
- Press event: a rising edge of STATE[i] with MASK[i]=1 sets EVENTS[i] and increments COUNT by 1.
  - COUNT is 8 bits and wraps 255 -> 0.
  - Several bits rising in the same cycle add the number of rising bits (popcount), modulo 256.
- Register map, word index = cpu_addr[3:2]; registers are zero-extended to 32 bits on read:
  - 0 STATE: read-only; writes are ignored.
  - 1 EVENTS: read; a write clears every bit where cpu_wdata[i]=1.
  - 2 MASK: read/write bits [7:0].
  - 3 COUNT: read; any write clears it to 0.
- Simultaneous events and writes:
  - Event set and W1C clear of the same EVENTS bit in one cycle: the set wins, so the bit stays 1.
  - Increment and COUNT clear in one cycle: the result is the increment value applied to 0.
  - A MASK write takes effect for edges occurring from the following cycle onward.
- Handshake FSM, states IDLE and ACK:
  - IDLE -> ACK when sel & (cpu_read | cpu_write). Write side effects commit on that same edge. cpu_rdata is captured from the pre-write register value and cpu_ready is set to 1.
  - ACK -> IDLE unconditionally on the next edge, with cpu_ready=0 and cpu_rdata=0.
  - A request still held in the ACK cycle is treated as a new access only after returning to IDLE, so a held request produces one ready pulse every 2 cycles.
  - cpu_read and cpu_write both high: treated as a write, and cpu_rdata returns the old value.
  - sel=0: no response. cpu_ready stays 0 and cpu_rdata stays 0, so the iobus may OR peripheral outputs together.

Optional Feature:
- Macro PERIPH_BUTTONS_IRQ_EN.
- When defined:
  - Adds output port irq (1 bit) = |EVENTS, registered, reset 0.
  - irq asserts 1 cycle after the EVENTS bit sets.
  - irq deasserts 1 cycle after the last EVENTS bit clears.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
1. Reset with g_buttons=8'h00, then read offset 0x8 -> cpu_ready pulses 1 cycle after the request; cpu_rdata=32'h000000FF. Reads at 0x0, 0x4 and 0xC return 0.
2. Set g_buttons[3]=1 and hold it, DEBOUNCE_CYCLES=4 -> STATE=8'h08 exactly 6 cycles after the change, EVENTS=8'h08, COUNT=1. A 3-cycle pulse on bit 5 leaves STATE, EVENTS and COUNT unchanged.
3. With EVENTS=8'h09, write 32'h00000001 to 0x4 -> read 0x4 returns 8'h08. A W1C of bit 3 in the same cycle bit 3 re-rises leaves bit 3 set.
4. Write 8'hF0 to MASK, then press bits 0 and 4 simultaneously -> EVENTS=8'h10, COUNT=1.
5. Produce 256 presses -> COUNT reads 0. Then press bits 0 and 1 together -> COUNT=2. A write to 0xC -> COUNT=0.
6. Hold cpu_read with sel=1 for 6 cycles -> exactly 3 ready pulses. Assert g_rst during the ACK cycle -> cpu_ready=0 on the next edge and MASK=8'hFF. With PERIPH_BUTTONS_IRQ_EN defined, a bit-2 press raises irq 1 cycle after EVENTS[2] sets, and irq clears after a W1C of 0x4.

Source files
------------

// File: rtl/periph_buttons.sv
// rtl/periph_buttons.sv - debounced button input peripheral on the iobus
//
// Purpose:
//   Synchronises and debounces eight raw button inputs, latches press events
//   into sticky write-1-to-clear flags, counts presses, and answers CPU
//   load/store accesses with a one-cycle registered ready pulse.
//
// Register map (word index = cpu_addr[3:2], zero-extended to 32 bits):
//   0 STATE  : debounced levels, read-only
//   1 EVENTS : sticky press flags, write 1 to clear
//   2 MASK   : per-button press enable, read/write [7:0], resets to 8'hFF
//   3 COUNT  : press counter (wraps), any write clears
//
// Ports:
//   g_clk      in   system clock, rising edge
//   g_rst      in   synchronous active-high reset
//   g_buttons  in   [7:0] raw asynchronous button levels, 1 = pressed
//   sel        in   iobus decode for this peripheral
//   cpu_addr   in   [3:0] byte offset, bits [3:2] select the register
//   cpu_read   in   read request, held until cpu_ready
//   cpu_write  in   write request, held until cpu_ready
//   cpu_wdata  in   [31:0] write data
//   cpu_rdata  out  [31:0] read data, valid while cpu_ready=1, else 0
//   cpu_ready  out  one-cycle access-complete pulse
//   irq        out  registered |EVENTS (only with PERIPH_BUTTONS_IRQ_EN)
//
// Build option:
//   PERIPH_BUTTONS_IRQ_EN - adds the irq output and its register.

module periph_buttons #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic        g_clk,
    input  logic        g_rst,
    input  logic [7:0]  g_buttons,
    input  logic        sel,
    input  logic [3:0]  cpu_addr,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready
`ifdef PERIPH_BUTTONS_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] REG_STATE  = 2'd0;
    localparam logic [1:0] REG_EVENTS = 2'd1;
    localparam logic [1:0] REG_MASK   = 2'd2;
    localparam logic [1:0] REG_COUNT  = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } hs_state_t;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [7:0]       sync1;
    logic [7:0]       sync2;
    logic [7:0]       btn_state;
    logic [CNT_W-1:0] deb_cnt [8];
    logic [7:0]       events;
    logic [7:0]       mask;
    logic [7:0]       count;
    logic [31:0]      rdata_q;
    hs_state_t        hs_state;
    hs_state_t        hs_next;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    logic [7:0]       btn_state_next;
    logic [CNT_W-1:0] deb_cnt_next [8];
    logic [7:0]       rise;
    logic [7:0]       press;
    logic [7:0]       press_cnt;
    logic [7:0]       events_next;
    logic [7:0]       mask_next;
    logic [7:0]       count_next;
    logic [7:0]       w1c_bits;
    logic             access;
    logic             wr_en;
    logic [1:0]       word;
    logic [7:0]       rd_val;

    // Address bits [1:0] and the upper write-data bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{cpu_addr[1:0], cpu_wdata[31:8]};

    // A new access is only accepted from IDLE, so a request still held
    // during the ACK cycle waits one cycle and yields a pulse every 2 cycles.
    assign access = (hs_state == IDLE) && sel && (cpu_read || cpu_write);
    // Read and write together is a write; the read data still shows the
    // pre-write value because rdata is captured from current registers.
    assign wr_en  = access && cpu_write;
    assign word   = cpu_addr[3:2];

    // Debounce: a differing sample must persist for DEBOUNCE_CYCLES
    // consecutive cycles; any agreeing sample restarts the count.
    always_comb begin
        btn_state_next = btn_state;
        for (int i = 0; i < 8; i++) begin
            deb_cnt_next[i] = '0;
            if (sync2[i] != btn_state[i]) begin
                if (deb_cnt[i] == CNT_LAST) begin
                    btn_state_next[i] = sync2[i];
                    deb_cnt_next[i]   = '0;
                end else begin
                    deb_cnt_next[i] = deb_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Press events are taken on the same edge STATE rises, gated by the
    // current MASK, so a MASK write only affects edges from the next cycle.
    assign rise  = btn_state_next & ~btn_state;
    assign press = rise & mask;

    always_comb begin
        press_cnt = 8'd0;
        for (int i = 0; i < 8; i++) begin
            press_cnt = press_cnt + {7'd0, press[i]};
        end
    end

    // Register write side effects. Setting an event beats clearing it,
    // and a COUNT clear is applied before adding this cycle's presses.
    always_comb begin
        w1c_bits    = (wr_en && word == REG_EVENTS) ? cpu_wdata[7:0] : 8'd0;
        events_next = (events & ~w1c_bits) | press;
        mask_next   = (wr_en && word == REG_MASK) ? cpu_wdata[7:0] : mask;
        count_next  = ((wr_en && word == REG_COUNT) ? 8'd0 : count) + press_cnt;
    end

    always_comb begin
        rd_val = 8'd0;
        case (word)
            REG_STATE:  rd_val = btn_state;
            REG_EVENTS: rd_val = events;
            REG_MASK:   rd_val = mask;
            REG_COUNT:  rd_val = count;
            default:    rd_val = 8'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Input path and register state
    // ------------------------------------------------------------------
    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            sync1     <= 8'd0;
            sync2     <= 8'd0;
            btn_state <= 8'd0;
            events    <= 8'd0;
            mask      <= 8'hFF;
            count     <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1     <= g_buttons;
            sync2     <= sync1;
            btn_state <= btn_state_next;
            events    <= events_next;
            mask      <= mask_next;
            count     <= count_next;
            for (int i = 0; i < 8; i++) begin
                deb_cnt[i] <= deb_cnt_next[i];
            end
        end
    end

    // Read data is captured at the accepting edge from the pre-write value.
    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            rdata_q <= 32'd0;
        end else if (access) begin
            rdata_q <= {24'd0, rd_val};
        end
    end

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            hs_state <= IDLE;
        end else begin
            hs_state <= hs_next;
        end
    end

    always_comb begin
        hs_next = hs_state;
        case (hs_state)
            IDLE:    hs_next = access ? ACK : IDLE;
            ACK:     hs_next = IDLE;
            default: hs_next = IDLE;
        endcase
    end

    // Outputs are zero outside ACK so iobus peripherals can be OR-combined.
    always_comb begin
        cpu_ready = 1'b0;
        cpu_rdata = 32'd0;
        if (hs_state == ACK) begin
            cpu_ready = 1'b1;
            cpu_rdata = rdata_q;
        end
    end

`ifdef PERIPH_BUTTONS_IRQ_EN
    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            irq <= 1'b0;
        end else begin
            irq <= |events;
        end
    end
`endif

endmodule

// File: tb/tb_periph_buttons.sv
// tb/tb_periph_buttons.sv - directed self-checking bench for periph_buttons

module tb_periph_buttons;

    logic        g_clk = 1'b0;
    logic        g_rst;
    logic [7:0]  g_buttons;
    logic        sel;
    logic [3:0]  cpu_addr;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
`ifdef PERIPH_BUTTONS_IRQ_EN
    logic        irq;
`endif

    int checks   = 0;
    int failures = 0;
    int pulses;

    periph_buttons #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (8)
    ) dut (
        .g_clk    (g_clk),
        .g_rst    (g_rst),
        .g_buttons(g_buttons),
        .sel      (sel),
        .cpu_addr (cpu_addr),
        .cpu_read (cpu_read),
        .cpu_write(cpu_write),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready)
`ifdef PERIPH_BUTTONS_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    always #5 g_clk = ~g_clk;

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
        sel = 1'b1; cpu_read = 1'b1; cpu_addr = a;
        tick();
        chk({tag, "_ready"}, {31'd0, cpu_ready}, 32'd1);
        chk(tag, cpu_rdata, exp);
        sel = 1'b0; cpu_read = 1'b0;
        tick();
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input string tag);
        sel = 1'b1; cpu_write = 1'b1; cpu_addr = a; cpu_wdata = d;
        tick();
        chk({tag, "_ready"}, {31'd0, cpu_ready}, 32'd1);
        sel = 1'b0; cpu_write = 1'b0;
        tick();
    endtask

    task automatic press(input logic [7:0] bits);
        g_buttons = bits;
        repeat (8) tick();
        g_buttons = 8'd0;
        repeat (8) tick();
    endtask

    initial begin
        g_rst = 1'b1; g_buttons = 8'd0; sel = 1'b0; cpu_addr = 4'd0;
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_wdata = 32'd0;

        // 1. reset state and register defaults
        tick(); tick();
        g_rst = 1'b0;
        chk("reset_ready", {31'd0, cpu_ready}, 32'd0);
        chk("reset_rdata", cpu_rdata, 32'd0);
        rd(4'h8, 32'h0000_00FF, "reset_mask");
        rd(4'h0, 32'd0, "reset_state");
        rd(4'h4, 32'd0, "reset_events");
        rd(4'hC, 32'd0, "reset_count");

        // 2. debounce latency: STATE rises on the 6th edge after the change
        g_buttons = 8'h08;
        repeat (4) tick();
        sel = 1'b1; cpu_read = 1'b1; cpu_addr = 4'h0;
        tick();                                   // edge 5: captures pre-edge-5 STATE
        chk("lat_pre_ready", {31'd0, cpu_ready}, 32'd1);
        chk("lat_pre_state", cpu_rdata, 32'd0);
        tick();                                   // edge 6: ACK -> IDLE
        chk("lat_gap_ready", {31'd0, cpu_ready}, 32'd0);
        tick();                                   // edge 7: captures post-edge-6 STATE
        chk("lat_post_state", cpu_rdata, 32'h08);
        sel = 1'b0; cpu_read = 1'b0;
        tick();
        rd(4'h4, 32'h08, "press3_events");
        rd(4'hC, 32'd1, "press3_count");
        g_buttons = 8'h00;
        repeat (5) tick();
        rd(4'h0, 32'h08, "release_still_high");  // access at edge 6 sees pre-edge-6
        repeat (8) tick();
        rd(4'h0, 32'd0, "release_state");
        g_buttons = 8'h20;
        repeat (3) tick();
        g_buttons = 8'h00;
        repeat (10) tick();
        rd(4'h0, 32'd0, "glitch_state");
        rd(4'h4, 32'h08, "glitch_events");
        rd(4'hC, 32'd1, "glitch_count");

        // 3. W1C of EVENTS, and set winning over a same-cycle clear
        press(8'h01);
        rd(4'h4, 32'h09, "events_09");
        wr(4'h4, 32'h1, "w1c_bit0");
        rd(4'h4, 32'h08, "w1c_result");
        wr(4'h4, 32'h8, "w1c_bit3");
        rd(4'h4, 32'd0, "w1c_all_clear");
        g_buttons = 8'h08;
        repeat (5) tick();
        wr(4'h4, 32'h8, "w1c_collide");          // commits on edge 6, same as the rise
        rd(4'h4, 32'h08, "set_beats_clear");
        rd(4'hC, 32'd3, "count_after_3");
        g_buttons = 8'h00;
        repeat (8) tick();

        // 4. MASK gates events and counting
        wr(4'h8, 32'hF0, "mask_wr");
        rd(4'h8, 32'hF0, "mask_rd");
        wr(4'hC, 32'h0, "count_clr");
        wr(4'h4, 32'hFF, "events_clr");
        press(8'h11);
        rd(4'h4, 32'h10, "masked_events");
        rd(4'hC, 32'd1, "masked_count");
        wr(4'h8, 32'hFF, "mask_restore");

        // 5. COUNT wrap, popcount, clear, and clear colliding with increment
        wr(4'hC, 32'h0, "count_clr2");
        for (int k = 0; k < 256; k++) press(8'h01);
        rd(4'hC, 32'd0, "count_wrap");
        press(8'h03);
        rd(4'hC, 32'd2, "count_popcount");
        wr(4'hC, 32'h0, "count_clr3");
        rd(4'hC, 32'd0, "count_cleared");
        g_buttons = 8'h01;
        repeat (5) tick();
        wr(4'hC, 32'h0, "count_clr_collide");    // commits on the rise edge
        rd(4'hC, 32'd1, "clear_plus_incr");
        g_buttons = 8'h00;
        repeat (8) tick();

        // 6. held request, sel=0, read+write, reset during ACK
        pulses = 0;
        sel = 1'b1; cpu_read = 1'b1; cpu_addr = 4'h8;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (cpu_ready) pulses++;
        end
        sel = 1'b0; cpu_read = 1'b0;
        tick();
        chk("held_read_pulses", pulses, 32'd3);

        cpu_read = 1'b1; cpu_addr = 4'h8;
        tick(); tick();
        chk("nosel_ready", {31'd0, cpu_ready}, 32'd0);
        chk("nosel_rdata", cpu_rdata, 32'd0);
        cpu_read = 1'b0;

        sel = 1'b1; cpu_read = 1'b1; cpu_write = 1'b1; cpu_addr = 4'h8; cpu_wdata = 32'h55;
        tick();
        chk("rw_old_value", cpu_rdata, 32'hFF);
        sel = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
        tick();
        rd(4'h8, 32'h55, "rw_is_write");

        wr(4'h8, 32'h0F, "mask_0f");
        sel = 1'b1; cpu_read = 1'b1; cpu_addr = 4'h8;
        tick();
        chk("pre_rst_ready", {31'd0, cpu_ready}, 32'd1);
        g_rst = 1'b1;
        tick();
        chk("rst_ack_ready", {31'd0, cpu_ready}, 32'd0);
        chk("rst_ack_rdata", cpu_rdata, 32'd0);
        cpu_read = 1'b0; cpu_write = 1'b1; cpu_wdata = 32'h0;
        tick();                                   // write held under reset must not commit
        chk("rst_wr_ready", {31'd0, cpu_ready}, 32'd0);
        g_rst = 1'b0; sel = 1'b0; cpu_write = 1'b0;
        tick();
        rd(4'h8, 32'hFF, "rst_mask");

`ifdef PERIPH_BUTTONS_IRQ_EN
        g_buttons = 8'h04;
        repeat (6) tick();                        // EVENTS[2] sets on edge 6
        chk("irq_not_yet", {31'd0, irq}, 32'd0);
        tick();
        chk("irq_raised", {31'd0, irq}, 32'd1);
        g_buttons = 8'h00;
        sel = 1'b1; cpu_write = 1'b1; cpu_addr = 4'h4; cpu_wdata = 32'h4;
        tick();                                   // EVENTS clears here
        chk("irq_hold", {31'd0, irq}, 32'd1);
        sel = 1'b0; cpu_write = 1'b0;
        tick();
        chk("irq_cleared", {31'd0, irq}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
